// File: rtl/gpio_link.sv
// gpio_link: half-duplex, word-serial message link between two boards on one clock.
// A send latches message_out, arbitrates for the link with link_req_o, then streams
// WORDS data words plus an XOR checksum word (flagged by link_last_o). The receive
// side rebuilds the message, checks the checksum and publishes it on message_in.
//
// Ports:
//   clock, reset          common clock; synchronous active-high reset
//   send, message_out     one-cycle send request and the message to transmit
//   message_in            last good received message
//   busy                  FSM not idle or a send is pending
//   done                  one-cycle pulse when our frame has been sent
//   received, rx_error    one-cycle pulse: good frame / bad checksum or aborted frame
//   link_*_o, link_*_i    request, word-valid, last-word and data to / from the peer
//   link_data_oe          data bus drive enable (high only while transmitting)
module gpio_link #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter bit          LEADER = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     send,
  input  logic [DATA_W*WORDS-1:0]  message_out,
  output logic [DATA_W*WORDS-1:0]  message_in,
  output logic                     busy,
  output logic                     done,
  output logic                     received,
  output logic                     rx_error,
  output logic                     link_req_o,
  input  logic                     link_req_i,
  output logic                     link_vld_o,
  input  logic                     link_vld_i,
  output logic                     link_last_o,
  input  logic                     link_last_i,
  output logic [DATA_W-1:0]        link_data_o,
  input  logic [DATA_W-1:0]        link_data_i,
  output logic                     link_data_oe
);

  localparam int unsigned MSG_W = DATA_W * WORDS;
  localparam int unsigned CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StReq, StTx, StRx, StFin} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pending;
  logic               r_rx_end;
  logic [MSG_W-1:0]   r_tx_buf;
  logic [MSG_W-1:0]   r_rx_buf;
  logic [MSG_W-1:0]   r_message_in;
  logic [DATA_W-1:0]  r_xor;
  logic               r_done;
  logic               r_received;
  logic               r_rx_error;
  logic               r_req;
  logic               r_vld;
  logic               r_last;
  logic [DATA_W-1:0]  r_data;
  logic               r_oe;

  logic               w_busy;
  logic               w_accept;
  logic [DATA_W-1:0]  w_tx_word;
  logic [DATA_W-1:0]  w_tx_csum;

  assign w_busy   = (r_state != StIdle) || r_pending;
  assign w_accept = send && !w_busy;

  // Word selected by the counter, and the checksum over the whole TX buffer.
  always_comb begin
    w_tx_word = '0;
    w_tx_csum = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      w_tx_csum = w_tx_csum ^ r_tx_buf[i*DATA_W +: DATA_W];
      if (r_cnt == CNT_W'(i)) begin
        w_tx_word = r_tx_buf[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_rx_end     <= 1'b0;
      r_tx_buf     <= '0;
      r_rx_buf     <= '0;
      r_message_in <= '0;
      r_xor        <= '0;
      r_done       <= 1'b0;
      r_received   <= 1'b0;
      r_rx_error   <= 1'b0;
      r_req        <= 1'b0;
      r_vld        <= 1'b0;
      r_last       <= 1'b0;
      r_data       <= '0;
      r_oe         <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_received <= 1'b0;
      r_rx_error <= 1'b0;

      if (w_accept) begin
        r_tx_buf  <= message_out;
        r_pending <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (link_req_i) begin
            r_state  <= StRx;
            r_cnt    <= '0;
            r_xor    <= '0;
            r_rx_end <= 1'b0;
          end else if (r_pending || w_accept) begin
            r_state <= StReq;
            r_req   <= 1'b1;
          end
        end

        StReq: begin
          if (link_req_i && !LEADER) begin
            // Yield to the peer; pending stays set so we retry after its frame.
            r_req    <= 1'b0;
            r_state  <= StRx;
            r_cnt    <= '0;
            r_xor    <= '0;
            r_rx_end <= 1'b0;
          end else begin
            // Outputs are registered, so word 0 is launched on the way into TX.
            // From here on the counter holds the number of data words launched.
            r_state <= StTx;
            r_data  <= r_tx_buf[DATA_W-1:0];
            r_vld   <= 1'b1;
            r_oe    <= 1'b1;
            r_cnt   <= CNT_ONE;
          end
        end

        StTx: begin
          if (r_last) begin
            r_state <= StFin;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_oe    <= 1'b0;
            r_data  <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt < CNT_WORDS) begin
            r_data <= w_tx_word;
            r_cnt  <= r_cnt + CNT_ONE;
          end else begin
            r_data <= w_tx_csum;
            r_last <= 1'b1;
          end
        end

        StFin: begin
          r_pending <= 1'b0;
          r_state   <= StIdle;
        end

        StRx: begin
          if (r_rx_end) begin
            // One cycle after the last word: the result pulse is showing now.
            r_rx_end <= 1'b0;
            if (r_pending) begin
              r_state <= StReq;
              r_req   <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end else if (link_vld_i) begin
            if (link_last_i) begin
              r_rx_end <= 1'b1;
              // A short frame is rejected even if its checksum happens to match.
              if ((r_cnt == CNT_WORDS) && (link_data_i == r_xor)) begin
                r_message_in <= r_rx_buf;
                r_received   <= 1'b1;
              end else begin
                r_rx_error <= 1'b1;
              end
            end else if (r_cnt == CNT_WORDS) begin
              r_rx_error <= 1'b1;
              r_state    <= StIdle;
            end else begin
              for (int unsigned i = 0; i < WORDS; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                  r_rx_buf[i*DATA_W +: DATA_W] <= link_data_i;
                end
              end
              r_xor <= r_xor ^ link_data_i;
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (!link_req_i) begin
            r_rx_error <= 1'b1;
            r_state    <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign message_in   = r_message_in;
  assign busy         = w_busy;
  assign done         = r_done;
  assign received     = r_received;
  assign rx_error     = r_rx_error;
  assign link_req_o   = r_req;
  assign link_vld_o   = r_vld;
  assign link_last_o  = r_last;
  assign link_data_o  = r_data;
  assign link_data_oe = r_oe;

endmodule

// File: tb/tb_gpio_link.sv
// Directed bench for gpio_link: a leader/follower pair cross-wired for loopback and
// arbitration, plus a standalone instance whose peer side is driven by the bench.
module tb_gpio_link;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int MW = DW * NW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Pair a (leader) <-> b (follower)
  logic          a_send, b_send;
  logic [MW-1:0] a_msg_out, b_msg_out, a_msg_in, b_msg_in;
  logic          a_busy, a_done, a_rcv, a_err, b_busy, b_done, b_rcv, b_err;
  logic          a_req, a_vld, a_last, a_oe, b_req, b_vld, b_last, b_oe;
  logic [DW-1:0] a_data, b_data;

  // Standalone c with bench-driven peer
  logic          c_send;
  logic [MW-1:0] c_msg_out, c_msg_in;
  logic          c_busy, c_done, c_rcv, c_err;
  logic          c_req_o, c_vld_o, c_last_o, c_oe;
  logic [DW-1:0] c_data_o;
  logic          c_req_i, c_vld_i, c_last_i;
  logic [DW-1:0] c_data_i;

  gpio_link #(.DATA_W(DW), .WORDS(NW), .LEADER(1'b1)) u_a (
    .clock(clock), .reset(reset), .send(a_send), .message_out(a_msg_out),
    .message_in(a_msg_in), .busy(a_busy), .done(a_done), .received(a_rcv),
    .rx_error(a_err), .link_req_o(a_req), .link_req_i(b_req), .link_vld_o(a_vld),
    .link_vld_i(b_vld), .link_last_o(a_last), .link_last_i(b_last),
    .link_data_o(a_data), .link_data_i(b_data), .link_data_oe(a_oe)
  );

  gpio_link #(.DATA_W(DW), .WORDS(NW), .LEADER(1'b0)) u_b (
    .clock(clock), .reset(reset), .send(b_send), .message_out(b_msg_out),
    .message_in(b_msg_in), .busy(b_busy), .done(b_done), .received(b_rcv),
    .rx_error(b_err), .link_req_o(b_req), .link_req_i(a_req), .link_vld_o(b_vld),
    .link_vld_i(a_vld), .link_last_o(b_last), .link_last_i(a_last),
    .link_data_o(b_data), .link_data_i(a_data), .link_data_oe(b_oe)
  );

  gpio_link #(.DATA_W(DW), .WORDS(NW), .LEADER(1'b0)) u_c (
    .clock(clock), .reset(reset), .send(c_send), .message_out(c_msg_out),
    .message_in(c_msg_in), .busy(c_busy), .done(c_done), .received(c_rcv),
    .rx_error(c_err), .link_req_o(c_req_o), .link_req_i(c_req_i), .link_vld_o(c_vld_o),
    .link_vld_i(c_vld_i), .link_last_o(c_last_o), .link_last_i(c_last_i),
    .link_data_o(c_data_o), .link_data_i(c_data_i), .link_data_oe(c_oe)
  );

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] csum(input logic [MW-1:0] m);
    logic [DW-1:0] x = '0;
    for (int i = 0; i < NW; i++) x = x ^ m[i*DW +: DW];
    return x;
  endfunction

  // Acts as the peer for u_c: request, n data words, then checksum (unless aborted).
  // Returns in the cycle after the last driven word.
  task automatic drive_frame(input logic [MW-1:0] m, input bit flip, input int n);
    c_req_i = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      c_vld_i  = 1'b1;
      c_data_i = m[i*DW +: DW];
      tick();
    end
    if (n == NW) begin
      c_vld_i  = 1'b1;
      c_last_i = 1'b1;
      c_data_i = csum(m) ^ {{(DW-1){1'b0}}, flip};
      tick();
    end
    c_req_i  = 1'b0;
    c_vld_i  = 1'b0;
    c_last_i = 1'b0;
    c_data_i = '0;
  endtask

  // Records the cycle (1-based after the send cycle) of the first pulse of each kind.
  task automatic watch_pair(output int ad, output int ar, output int bd, output int br,
                            output int n);
    ad = -1; ar = -1; bd = -1; br = -1; n = 0;
    for (int c = 1; c <= 18; c++) begin
      if (a_done) begin ad = c; n++; end
      if (a_rcv)  begin ar = c; n++; end
      if (b_done) begin bd = c; n++; end
      if (b_rcv)  begin br = c; n++; end
      if (a_err || b_err) n++;
      tick();
    end
  endtask

  logic [MW-1:0] tx_msg, rx1, rx2, lb_msg, s_a, s_b;
  int ad, ar, bd, br, np, seen;

  initial begin
    a_send = 0; b_send = 0; c_send = 0;
    a_msg_out = '0; b_msg_out = '0; c_msg_out = '0;
    c_req_i = 0; c_vld_i = 0; c_last_i = 0; c_data_i = '0;
    tx_msg = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    rx1    = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 32'h9ABCDEF0};
    rx2    = {32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008};
    lb_msg = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
    s_a    = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    s_b    = 128'hF0E0D0C0_B0A09080_70605040_30201000;

    tick(); tick();
    reset = 1'b0;
    check("reset_outputs", {c_busy, c_done, c_rcv, c_err, c_req_o, c_vld_o, c_last_o,
                            c_oe, c_data_o}, '0);
    check("reset_msg_in", c_msg_in, '0);
    check("reset_pair_busy", {a_busy, b_busy, a_req, b_req}, '0);

    // Basic transmit; a second send during TX must be ignored.
    tick();
    c_msg_out = tx_msg;
    c_send    = 1'b1;
    check("tx_c0_busy", c_busy, 1'b0);
    tick();
    c_send = 1'b0;
    check("tx_c1_req", {c_req_o, c_vld_o, c_oe, c_busy}, 4'b1001);
    for (int k = 0; k < NW; k++) begin
      tick();
      if (k == 1) begin
        c_send    = 1'b1;
        c_msg_out = '1;
      end else begin
        c_send = 1'b0;
      end
      check($sformatf("tx_word%0d", k), {c_vld_o, c_last_o, c_oe, c_data_o},
            {3'b101, tx_msg[k*DW +: DW]});
    end
    tick();
    c_send = 1'b0;
    check("tx_csum", {c_vld_o, c_last_o, c_oe, c_data_o}, {3'b111, 32'h44444444});
    tick();
    check("tx_done", {c_done, c_req_o, c_oe, c_vld_o, c_busy}, 5'b10001);
    tick();
    check("tx_idle", {c_done, c_busy, c_req_o}, 3'b000);
    tick(); tick();
    check("tx_busy_send_ignored", {c_busy, c_req_o}, 2'b00);

    // Good receive
    tick();
    drive_frame(rx1, 1'b0, NW);
    check("rx_good_pulse", {c_rcv, c_err, c_done}, 3'b100);
    check("rx_good_msg", c_msg_in, rx1);
    tick();
    check("rx_good_single", {c_rcv, c_err, c_busy}, 3'b000);

    // Corrupt checksum
    tick();
    drive_frame(rx2, 1'b1, NW);
    check("rx_bad_pulse", {c_rcv, c_err}, 2'b01);
    check("rx_bad_msg_held", c_msg_in, rx1);

    // Abort after 2 words
    tick(); tick();
    drive_frame(rx2, 1'b0, 2);
    check("abort_early", c_err, 1'b0);
    tick();
    check("abort_err", {c_err, c_rcv, c_busy}, 3'b100);
    check("abort_msg_held", c_msg_in, rx1);
    tick();
    check("abort_single", c_err, 1'b0);

    // Loopback a -> b
    tick();
    a_msg_out = lb_msg;
    a_send    = 1'b1;
    tick();
    a_send = 1'b0;
    watch_pair(ad, ar, bd, br, np);
    check("loop_a_done_cyc", ad, 7);
    check("loop_b_recv_cyc", br, 7);
    check("loop_pulses", np, 2);
    check("loop_msg", b_msg_in, lb_msg);

    // Simultaneous sends: leader frame first, then follower retries.
    a_msg_out = s_a;
    b_msg_out = s_b;
    a_send    = 1'b1;
    b_send    = 1'b1;
    tick();
    a_send = 1'b0;
    b_send = 1'b0;
    watch_pair(ad, ar, bd, br, np);
    check("sim_a_done_cyc", ad, 7);
    check("sim_b_recv_cyc", br, 7);
    check("sim_b_done_cyc", bd, 14);
    check("sim_a_recv_cyc", ar, 14);
    check("sim_pulses", np, 4);
    check("sim_b_msg", b_msg_in, s_a);
    check("sim_a_msg", a_msg_in, s_b);
    check("sim_idle", {a_busy, b_busy}, 2'b00);

    // Reset during TX word 2
    c_msg_out = tx_msg;
    c_send    = 1'b1;
    tick();
    c_send = 1'b0;
    tick(); tick(); tick();
    check("rst_tx_word2", c_data_o, 32'h33333333);
    reset = 1'b1;
    tick();
    check("rst_outputs", {c_busy, c_done, c_rcv, c_err, c_req_o, c_vld_o, c_last_o,
                          c_oe, c_data_o}, '0);
    check("rst_msg_in", b_msg_in, '0);
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      if (c_done || c_busy) seen++;
      tick();
    end
    check("rst_no_done", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
